// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch front end for the 5-stage core.
//
// Holds the fetch PC and issues in-order word requests to instruction memory
// over a valid/ready channel. Returned words go into a small prefetch FIFO
// together with their PC. The FIFO head is presented to the IF/ID register as
// {instr, pc, pc+4} with a valid/ready handshake. A branch redirect from MEM
// flushes the FIFO, restarts fetch at the new address and marks every
// in-flight response as stale so it is discarded on arrival.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   imem_req_valid_o   fetch request valid
//   imem_req_ready_i   imem accepts the request this cycle
//   imem_req_addr_o    word-aligned fetch address
//   imem_rsp_valid_i   response word valid (request order, latency >= 1)
//   imem_rsp_data_i    response instruction word
//   redirect_i         branch taken / flush, single-cycle pulse
//   redirect_pc_i      new fetch address (bits [1:0] ignored)
//   instr_valid_o      FIFO head valid
//   instr_ready_i      IF/ID accepts the head (low = stall)
//   instr_o            head instruction (NOP when empty)
//   pc_o               PC of head instruction (holds last value when empty)
//   pc_incr_o          pc_o + 4
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_incr_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  function automatic logic [31:0] f_pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Control state
  logic          r_run;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_stale;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [31:0]   r_pc_hold;

  // Prefetch storage (data only, not reset)
  logic [31:0]   r_instr_mem [FIFO_DEPTH];
  logic [31:0]   r_pc_mem    [FIFO_DEPTH];

  logic [CW-1:0] w_live;
  logic [CW:0]   w_occ;
  logic          w_req_valid;
  logic          w_fire;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic [31:0]   w_redir_pc;
  logic [31:0]   w_pc_head;

  // Live responses are those still destined for the FIFO; together with the
  // current occupancy they must fit, so a push never finds the FIFO full.
  assign w_live      = r_inflight - r_stale;
  assign w_occ       = {1'b0, r_count} + {1'b0, w_live};
  // r_run keeps requests off during reset and for the first cycle after it.
  assign w_req_valid = r_run && !redirect_i && (r_inflight < DEPTH_C)
                       && (w_occ < {1'b0, DEPTH_C});
  assign w_fire      = w_req_valid && imem_req_ready_i;

  assign w_empty     = (r_count == '0);
  // A response is kept only when nothing stale is ahead of it and no redirect
  // is flushing the path this cycle.
  assign w_push      = imem_rsp_valid_i && (r_stale == '0) && !redirect_i;
  // A pop during a redirect belongs to the flushed path and is void.
  assign w_pop       = !w_empty && instr_ready_i && !redirect_i;

  assign w_redir_pc  = redirect_pc_i & 32'hFFFF_FFFC;

  assign w_pc_head   = w_empty ? r_pc_hold : r_pc_mem[r_rptr];

  assign imem_req_valid_o = w_req_valid;
  assign imem_req_addr_o  = r_fetch_pc;
  assign instr_valid_o    = !w_empty;
  assign instr_o          = w_empty ? NOP : r_instr_mem[r_rptr];
  assign pc_o             = w_pc_head;
  assign pc_incr_o        = f_pc_inc(w_pc_head);

  // Control registers: fetch PC, response PC, counters, pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_count    <= '0;
      r_inflight <= '0;
      r_stale    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_pc_hold  <= '0;
    end else begin
      r_run     <= 1'b1;
      r_pc_hold <= w_pc_head;
      if (redirect_i) begin
        // Everything still outstanding after this cycle's response (which is
        // itself dropped) belongs to the old path.
        r_fetch_pc <= w_redir_pc;
        r_rsp_pc   <= w_redir_pc;
        r_count    <= '0;
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_inflight <= r_inflight - CW'(imem_rsp_valid_i);
        r_stale    <= r_inflight - CW'(imem_rsp_valid_i);
      end else begin
        if (w_fire) begin
          r_fetch_pc <= f_pc_inc(r_fetch_pc);
        end
        r_inflight <= r_inflight + CW'(w_fire) - CW'(imem_rsp_valid_i);
        if (imem_rsp_valid_i && (r_stale != '0)) begin
          r_stale <= r_stale - CW'(1);
        end
        if (w_push) begin
          r_wptr   <= r_wptr + AW'(1);
          r_rsp_pc <= f_pc_inc(r_rsp_pc);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + AW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // FIFO write port
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wptr] <= imem_rsp_data_i;
      r_pc_mem[r_wptr]    <= r_rsp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. A small instruction-memory model answers
// accepted requests in order (latency 1 when enabled, held back when not);
// the word returned for address A is A ^ 32'hDEAD_0000.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_incr_o;

  int          n_assert = 0;
  int          n_fail   = 0;
  bit          rsp_en;
  logic [31:0] q[$];

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .instr_valid_o    (instr_valid_o),
    .instr_ready_i    (instr_ready_i),
    .instr_o          (instr_o),
    .pc_o             (pc_o),
    .pc_incr_o        (pc_incr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: capture the request handshake, cross the edge, then let the
  // memory model present the next response. Redirect is a one-cycle pulse.
  task automatic tick();
    logic        fire;
    logic [31:0] a;
    #1;
    fire = imem_req_valid_o && imem_req_ready_i;
    a    = imem_req_addr_o;
    @(posedge clk);
    #1;
    if (fire) q.push_back(a);
    redirect_i = 1'b0;
    if (rsp_en && q.size() > 0) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = q.pop_front() ^ 32'hDEAD_0000;
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = 32'h0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    q.delete();
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'h0;
    redirect_i       = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int max);
    int k;
    k = 0;
    while (!instr_valid_o && k < max) begin
      tick();
      k++;
    end
    chk(tag, {31'b0, instr_valid_o}, 32'd1);
  endtask

  initial begin
    rst_n            = 1'b0;
    imem_req_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'h0;
    redirect_i       = 1'b0;
    redirect_pc_i    = 32'h0;
    instr_ready_i    = 1'b1;
    rsp_en           = 1'b1;

    // Reset values
    #2;
    chk("rst_valid",   {31'b0, instr_valid_o},    32'd0);
    chk("rst_instr",   instr_o,                   32'h0000_0013);
    chk("rst_pc",      pc_o,                      32'h0);
    chk("rst_pcincr",  pc_incr_o,                 32'h4);
    chk("rst_reqv",    {31'b0, imem_req_valid_o}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // 1: streaming fetch after reset
    #1;
    chk("t1_reqv_c0",  {31'b0, imem_req_valid_o}, 32'd0);
    tick();
    chk("t1_reqv_c1",  {31'b0, imem_req_valid_o}, 32'd1);
    chk("t1_addr_c1",  imem_req_addr_o,           32'h0);
    tick();
    chk("t1_valid_c2", {31'b0, instr_valid_o},    32'd0);
    tick();
    chk("t1_valid_c3", {31'b0, instr_valid_o},    32'd1);
    chk("t1_pc0",      pc_o,                      32'h0);
    chk("t1_instr0",   instr_o,                   32'hDEAD_0000);
    chk("t1_incr0",    pc_incr_o,                 32'h4);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("t1_valid",  {31'b0, instr_valid_o},    32'd1);
      chk("t1_pc",     pc_o,                      32'(4 * k));
      chk("t1_instr",  instr_o,                   32'hDEAD_0000 ^ 32'(4 * k));
    end

    // 2: stall for 10 cycles, then release
    instr_ready_i = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("t2_reqv_stall", {31'b0, imem_req_valid_o}, 32'd0);
    chk("t2_addr_stall", imem_req_addr_o,           32'h2C);
    chk("t2_valid_stall",{31'b0, instr_valid_o},    32'd1);
    chk("t2_pc_stall",   pc_o,                      32'h1C);
    chk("t2_instr_stall",instr_o,                   32'hDEAD_001C);
    instr_ready_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("t2_valid",    {31'b0, instr_valid_o},    32'd1);
      chk("t2_pc",       pc_o,                      32'h1C + 32'(4 * k));
    end

    // 3: three requests outstanding when the redirect arrives
    rsp_en = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) tick();
    chk("t3_reqv_c4",  {31'b0, imem_req_valid_o}, 32'd1);
    chk("t3_addr_c4",  imem_req_addr_o,           32'hC);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h100;
    rsp_en        = 1'b1;
    #1;
    chk("t3_reqv_redir", {31'b0, imem_req_valid_o}, 32'd0);
    tick();
    chk("t3_addr_c5",  imem_req_addr_o,           32'h100);
    chk("t3_reqv_c5",  {31'b0, imem_req_valid_o}, 32'd1);
    chk("t3_valid_c5", {31'b0, instr_valid_o},    32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_valid_drop", {31'b0, instr_valid_o}, 32'd0);
    end
    tick();
    chk("t3_valid_c9", {31'b0, instr_valid_o},    32'd1);
    chk("t3_pc",       pc_o,                      32'h100);
    chk("t3_instr",    instr_o,                   32'hDEAD_0100);
    chk("t3_incr",     pc_incr_o,                 32'h104);
    tick();
    chk("t3_pc_next",  pc_o,                      32'h104);

    // 4: misaligned redirect target is word-aligned
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h102;
    tick();
    chk("t4_addr",     imem_req_addr_o,           32'h100);
    wait_valid("t4_timeout", 20);
    chk("t4_pc",       pc_o,                      32'h100);
    chk("t4_incr",     pc_incr_o,                 32'h104);
    chk("t4_instr",    instr_o,                   32'hDEAD_0100);

    // 5: redirect together with a response and a pop
    rsp_en = 1'b0;
    do_reset();
    for (int k = 0; k < 3; k++) tick();
    rsp_en = 1'b1;
    tick();
    tick();
    chk("t5_valid_pre", {31'b0, instr_valid_o},    32'd1);
    chk("t5_pc_pre",    pc_o,                      32'h0);
    chk("t5_rsp_pre",   {31'b0, imem_rsp_valid_i}, 32'd1);
    chk("t5_reqv_pre",  {31'b0, imem_req_valid_o}, 32'd0);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    tick();
    chk("t5_valid_flush", {31'b0, instr_valid_o},    32'd0);
    chk("t5_instr_nop",   instr_o,                   32'h0000_0013);
    chk("t5_pc_hold",     pc_o,                      32'h0);
    chk("t5_addr",        imem_req_addr_o,           32'h200);
    chk("t5_reqv",        {31'b0, imem_req_valid_o}, 32'd1);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("t5_valid_drop", {31'b0, instr_valid_o},   32'd0);
    end
    tick();
    chk("t5_valid",    {31'b0, instr_valid_o},    32'd1);
    chk("t5_pc",       pc_o,                      32'h200);
    chk("t5_instr",    instr_o,                   32'hDEAD_0200);

    // 6: asynchronous reset with 2 buffered and 2 in flight
    instr_ready_i = 1'b0;
    tick();
    chk("t6_valid_pre", {31'b0, instr_valid_o},    32'd1);
    chk("t6_pc_pre",    pc_o,                      32'h200);
    chk("t6_reqv_pre",  {31'b0, imem_req_valid_o}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_valid_rst", {31'b0, instr_valid_o},    32'd0);
    chk("t6_instr_rst", instr_o,                   32'h0000_0013);
    chk("t6_pc_rst",    pc_o,                      32'h0);
    chk("t6_incr_rst",  pc_incr_o,                 32'h4);
    chk("t6_reqv_rst",  {31'b0, imem_req_valid_o}, 32'd0);
    instr_ready_i = 1'b1;
    do_reset();
    tick();
    chk("t6_reqv_restart", {31'b0, imem_req_valid_o}, 32'd1);
    chk("t6_addr_restart", imem_req_addr_o,           32'h0);
    tick();
    tick();
    chk("t6_valid_restart", {31'b0, instr_valid_o},   32'd1);
    chk("t6_pc_restart",    pc_o,                     32'h0);

    // 7: fetch PC wraps from 0xFFFF_FFFC to 0
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFF8;
    tick();
    wait_valid("t7_timeout", 20);
    chk("t7_pc0",      pc_o,                      32'hFFFF_FFF8);
    chk("t7_instr0",   instr_o,                   32'h2152_FFF8);
    chk("t7_incr0",    pc_incr_o,                 32'hFFFF_FFFC);
    tick();
    chk("t7_pc1",      pc_o,                      32'hFFFF_FFFC);
    chk("t7_incr1",    pc_incr_o,                 32'h0);
    chk("t7_instr1",   instr_o,                   32'h2152_FFFC);
    tick();
    chk("t7_valid2",   {31'b0, instr_valid_o},    32'd1);
    chk("t7_pc2",      pc_o,                      32'h0);
    chk("t7_instr2",   instr_o,                   32'hDEAD_0000);
    chk("t7_incr2",    pc_incr_o,                 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected completion before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
